// File: rtl/huff_byte_tx.sv
// huff_byte_tx
// Takes a packed Huffman bitstream (bus + valid-bit count) on a one-cycle
// start pulse. It then streams the frame out LSB-first as 8-bit bytes over a
// valid/ready handshake. The final byte is flagged with tx_last, together
// with the number of zero pad bits it carries.
//
// Optional feature: define HUFF_BYTE_TX_CRC_EN to append one CRC-8 byte
// (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) computed over
// all data bytes including pad zeros. tx_last then marks the CRC byte, with
// tx_pad = 0.
//
// Ports:
//   CLK        clock, rising edge
//   nRST       asynchronous active-low reset
//   start      one-cycle pulse, bits_in/bit_count valid this cycle
//   bits_in    encoded stream, bit 0 is transmitted first
//   bit_count  number of valid bits in bits_in (clamped to DATA_W)
//   busy       high while a frame is held (SEND/CRC/DONE)
//   tx_data    current byte, stream bit 8k+j -> byte k bit j
//   tx_valid   tx_data valid
//   tx_ready   sink accepts byte
//   tx_last    current byte is the final byte of the frame
//   tx_pad     zero pad bits in the final byte (valid with tx_last)
//   done       one-cycle pulse after the frame completes
module huff_byte_tx #(
  parameter int DATA_W  = 1024,
  parameter int CNT_W   = 11,
  parameter int NBYTE_W = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [DATA_W-1:0] bits_in,
  input  logic [CNT_W-1:0]  bit_count,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic [2:0]        tx_pad,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef HUFF_BYTE_TX_CRC_EN
  localparam logic [1:0] S_CRC  = 2'd3;
`endif

  logic [1:0]         state;
  logic [DATA_W-1:0]  shreg;
  logic [NBYTE_W-1:0] remaining;
  logic               last_data;

  // Capture-side decode: clamp the count, mask the bits beyond it, and derive
  // the byte count and pad.
  logic [CNT_W-1:0]   cnt_clamp;
  logic [CNT_W-1:0]   cnt_round;
  logic [DATA_W-1:0]  cap_mask;
  logic [NBYTE_W-1:0] cap_nbytes;

  always_comb begin
    cnt_clamp  = (bit_count > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : bit_count;
    cnt_round  = cnt_clamp + CNT_W'(7);
    // A shift by DATA_W yields all zeros, so a full-width count keeps every bit.
    cap_mask   = ~({DATA_W{1'b1}} << cnt_clamp);
    cap_nbytes = NBYTE_W'(cnt_round >> 3);
  end

  assign last_data = (remaining == NBYTE_W'(1));

`ifdef HUFF_BYTE_TX_CRC_EN
  logic [7:0] crc_q;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`else
  logic [2:0] cap_pad;
  logic [2:0] pad_q;

  // (8 - count%8) % 8 equals the two's-complement negation of the low 3 bits.
  assign cap_pad = 3'd0 - cnt_clamp[2:0];
`endif

  // Control and frame storage
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      shreg     <= '0;
      remaining <= '0;
`ifdef HUFF_BYTE_TX_CRC_EN
      crc_q     <= 8'd0;
`else
      pad_q     <= 3'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg     <= bits_in & cap_mask;
            remaining <= cap_nbytes;
`ifdef HUFF_BYTE_TX_CRC_EN
            crc_q     <= 8'd0;
            state     <= (cap_nbytes != '0) ? S_SEND : S_CRC;
`else
            pad_q     <= cap_pad;
            state     <= (cap_nbytes != '0) ? S_SEND : S_DONE;
`endif
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            shreg     <= shreg >> 8;
            remaining <= remaining - NBYTE_W'(1);
`ifdef HUFF_BYTE_TX_CRC_EN
            crc_q     <= crc8_byte(crc_q, shreg[7:0]);
            if (last_data) state <= S_CRC;
`else
            if (last_data) state <= S_DONE;
`endif
          end
        end
`ifdef HUFF_BYTE_TX_CRC_EN
        S_CRC: begin
          if (tx_ready) state <= S_DONE;
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so they stay stable while
  // the sink stalls and drop to zero immediately on reset.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    tx_last  = 1'b0;
    tx_pad   = 3'd0;
    if (state == S_SEND) begin
      tx_valid = 1'b1;
      tx_data  = shreg[7:0];
`ifndef HUFF_BYTE_TX_CRC_EN
      tx_last  = last_data;
      tx_pad   = last_data ? pad_q : 3'd0;
`endif
    end
`ifdef HUFF_BYTE_TX_CRC_EN
    if (state == S_CRC) begin
      tx_valid = 1'b1;
      tx_data  = crc_q;
      tx_last  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_huff_byte_tx.sv
module tb_huff_byte_tx;
  localparam int DATA_W = 1024;
  localparam int CNT_W  = 11;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] bits_in = '0;
  logic [CNT_W-1:0]  bit_count = '0;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic [2:0]        tx_pad;
  logic              done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  huff_byte_tx dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .bits_in   (bits_in),
    .bit_count (bit_count),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .tx_pad    (tx_pad),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef HUFF_BYTE_TX_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  // Runs one frame against exp_q. Outputs are sampled on the falling edge;
  // tx_ready driven at that edge governs the next rising edge.
  task automatic frame(input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] data,
                       input logic [2:0] pad, input bit toggle, input int restart_cyc);
    int n;
    int idx;
    int cyc;
    bit seen_done;
    bit rdy;
    logic [2:0] lpad;
`ifdef HUFF_BYTE_TX_CRC_EN
    logic [7:0] crc;
`endif
    lpad = pad;
`ifdef HUFF_BYTE_TX_CRC_EN
    crc = 8'h00;
    foreach (exp_q[i]) crc = crc8(crc, exp_q[i]);
    exp_q.push_back(crc);
    lpad = 3'd0;
`endif
    n = exp_q.size();
    idx = 0;
    cyc = 0;
    seen_done = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    bit_count = cnt;
    bits_in = data;
    tx_ready = 1'b0;
    while (!seen_done && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      start = 1'b0;
      if (cyc == restart_cyc) begin
        start = 1'b1;
        bit_count = 11'd16;
        bits_in = {DATA_W{1'b1}};
      end
      if (cyc == 1) chk("latency_valid", tx_valid, n > 0);
      chk("busy_in_frame", busy, 1);
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      tx_ready = rdy;
      if (tx_valid) begin
        if (idx < n) begin
          chk("byte_data", tx_data, exp_q[idx]);
          chk("byte_last", tx_last, idx == n - 1);
          chk("byte_pad", tx_pad, (idx == n - 1) ? lpad : 3'd0);
          if (rdy) idx++;
        end else begin
          chk("extra_byte_valid", tx_valid, 0);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk("bytes_at_done", idx, n);
        chk("valid_at_done", tx_valid, 0);
        if (!toggle) chk("done_cycle", cyc, n + 1);
      end
    end
    chk("done_seen", seen_done, 1);
    start = 1'b0;
    @(negedge CLK);
    tx_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", tx_valid, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;

    // Reset state
    @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_pad", tx_pad, 0);
    chk("rst_done", done, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // 10 bits with ones above the count: upper byte must come out masked
    d = {DATA_W{1'b1}};
    d[9:0] = 10'b11_0101_1010;
    exp_q = '{8'h5A, 8'h03};
    frame(11'd10, d, 3'd6, 1'b0, -1);

    // Full-width frame: 128 bytes of 0xFF
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(8'hFF);
    frame(11'd1024, {DATA_W{1'b1}}, 3'd0, 1'b0, -1);

    // Over-range count clamps to DATA_W
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(8'hFF);
    frame(11'd2000, {DATA_W{1'b1}}, 3'd0, 1'b0, -1);

    // Back-pressure: ready toggles, bytes held across stalls
    d = {DATA_W{1'b1}};
    d[15:0] = 16'hBEEF;
    exp_q = '{8'hEF, 8'hBE};
    frame(11'd16, d, 3'd0, 1'b1, -1);

    // Zero-length frame
    exp_q.delete();
    frame(11'd0, {DATA_W{1'b1}}, 3'd0, 1'b0, -1);

    // Second start during SEND is ignored
    d = '0;
    d[39:0] = 40'h11_2233_4455;
    exp_q = '{8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    frame(11'd40, d, 3'd0, 1'b0, 2);

    // Reset mid-frame after two of five bytes
    d = '0;
    d[39:0] = 40'hCA_FEBA_BE01;
    @(negedge CLK);
    start = 1'b1;
    bit_count = 11'd40;
    bits_in = d;
    tx_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("mid_b0", tx_data, 8'h01);
    @(negedge CLK);
    chk("mid_b1", tx_data, 8'hBE);
    @(negedge CLK);
    chk("mid_b2", tx_data, 8'hBA);
    nRST = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_last", tx_last, 0);
    chk("mid_rst_pad", tx_pad, 0);
    chk("mid_rst_done", done, 0);
    @(negedge CLK);
    chk("mid_rst_hold_done", done, 0);
    chk("mid_rst_hold_busy", busy, 0);
    nRST = 1'b1;
    tx_ready = 1'b0;

    // Fresh frame after reset
    d = '0;
    d[7:0] = 8'hA5;
    exp_q = '{8'hA5};
    frame(11'd8, d, 3'd0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
